jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from JK-style storage cells.
- Its excitation logic generates per-bit J/K from the current count and the control inputs.
- Sits directly upstream of the JK flip-flop bank consumers: its exported j_out/k_out vectors drive discrete JK flip-flops elsewhere in the design, and its own q is the reference count.
- Adds load handshake, wrap-around and terminal-count flagging.

Parameters:
- WIDTH, 4, count width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous active-high reset. Single clock domain.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when en=1.
- load_valid  input  1  load request.
- load_value  input  WIDTH  value to load.
- load_ready  output  1  load can be accepted this cycle.
- load_err  output  1  one-cycle pulse: out-of-range load was clamped.
- q  output  WIDTH  current count.
- j_out  output  WIDTH  J excitation for the next edge (combinational from q and controls).
- k_out  output  WIDTH  K excitation for the next edge.
- tc  output  1  terminal count: q==MODULUS-1 when up=1, q==0 when up=0.

Behaviour:
- Reset (clr=1 at a rising edge): q=0, load_err=0, FSM state=IDLE. load_ready=0 during any cycle where clr=1. clr overrides every other input, including mid-load.
- FSM states: IDLE, RUN, LOADED.
  - IDLE: q held.
  - IDLE -> RUN when en=1.
  - Any state -> LOADED on load accept.
  - LOADED -> RUN next cycle if en=1, else -> IDLE.
  - RUN -> IDLE when en=0.
- load_ready = !clr. Accept = load_valid & load_ready.
  - Accept has priority over counting in the same cycle.
  - q <= load_value, or MODULUS-1 if load_value >= MODULUS.
  - load_err <= 1 for exactly one cycle when clamped, else 0.
- Counting (en=1, no accept), latency 1 cycle:
  - up=1: q <= (q==MODULUS-1) ? 0 : q+1.
  - up=0: q <= (q==0) ? MODULUS-1 : q-1.
- en=0, no accept: q holds. j_out=k_out=0 in that case.
- Excitation rule, per bit i, with next = computed next q:
  - q[i]=0, next[i]=1 -> J=1, K=0.
  - q[i]=1, next[i]=0 -> J=0, K=1.
  - Unchanged bit -> J=0, K=0.
  - Never J=K=1. The toggle encoding is reserved so that external flip-flops stay deterministic.
  - On a load, j_out/k_out encode the transition to the loaded (clamped) value.
- Internal q is updated only through the jk_cell instances driven by j_out/k_out, so q and any external JK bank fed the same excitation always match.
- tc is combinational from q and up, and is independent of en.
- q out of range cannot occur: loads clamp and arithmetic wraps.
- Simultaneous direction change and wrap: use up as sampled in that cycle.

Decomposition:
- Package jk_pkg:
  - FSM state typedef (IDLE/RUN/LOADED, 2-bit).
  - JK encoding constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11. JK_TOGGLE is defined but unused here.
- Sub-module jk_cell: one JK storage bit with synchronous active-high clr. Instantiate WIDTH times via generate.
- Next-value and excitation logic stays in the top module.

Test Plan:
- Reset then count: clr=1 for 2 cycles, then en=1, up=1 for 12 cycles -> q goes 0,1..9,0,1. tc=1 only while q=9. j_out/k_out never both 1 on any bit.
- Down wrap: load 0, then en=1, up=0 -> q=9 one cycle later, then 8. At q=0 with up=0, tc=1.
- Clamped load: load_valid=1, load_value=13 -> q=9 next cycle, load_err=1 for exactly one cycle. load_value=5 -> q=5, load_err=0.
- Load vs count priority: q=3, en=1, up=1, load_valid=1, load_value=7 in the same cycle -> q=7, not 4. FSM goes to LOADED, then RUN, and q=8 on the following edge.
- Reset mid-operation: q=6 counting with load_valid=1 and clr=1 -> q=0, load_err=0, load_ready=0 during clr. Load is ignored.
- Hold: en=0 for 5 cycles at q=4 -> q stays 4, j_out=k_out=0. A shadow external JK bank driven by j_out/k_out matches q every cycle throughout all tests.

Source files
------------

// File: rtl/jk_mod_counter_pkg.sv
// Shared types and JK excitation encodings for the modulo-N JK counter.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOADED = 2'd2
  } state_t;

  // {J, K} pairs as presented to a JK storage cell.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  // Reserved: never emitted, so external JK banks stay deterministic.
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_mod_counter_if.sv
// Load handshake bus for jk_mod_counter, plus the FSM state as a status field.
import jk_pkg::*;

interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             load_err;
  state_t           state;

  modport master (
    output load_valid, load_value,
    input  load_ready, load_err, state
  );

  modport slave (
    input  load_valid, load_value,
    output load_ready, load_err, state
  );
endinterface

// File: rtl/jk_mod_counter_cell.sv
// One JK storage bit with synchronous active-high clear.
import jk_pkg::*;

module jk_cell (
  input  logic clk,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK flip-flop behaviour; clear wins over any excitation.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_SET:    q <= 1'b1;
        JK_RESET:  q <= 1'b0;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose count lives in JK cells; exports the
// per-bit J/K excitation so an external JK bank can track the same count.
import jk_pkg::*;

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  jk_mod_counter_if.slave       ld,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      j_out,
  output logic [WIDTH-1:0]      k_out,
  output logic                  tc
);

  localparam logic [WIDTH-1:0] QMAX  = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic             accept;
  logic             clamp;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] nxt;
  state_t           state;

  assign ld.load_ready = ~clr;
  assign accept        = ld.load_valid & ld.load_ready;
  assign clamp         = ({1'b0, ld.load_value} >= MOD_W);
  assign load_q        = clamp ? QMAX : ld.load_value;
  assign tc            = up ? (q == QMAX) : (q == '0);
  assign ld.state      = state;

  // Next count: a load beats counting; counting wraps at both ends.
  always_comb begin
    nxt = q;
    if (accept) begin
      nxt = load_q;
    end else if (en) begin
      if (up) nxt = (q == QMAX) ? '0 : q + WIDTH'(1);
      else    nxt = (q == '0) ? QMAX : q - WIDTH'(1);
    end
  end

  // Per-bit excitation: set on 0->1, reset on 1->0, hold otherwise.
  always_comb begin
    j_out = '0;
    k_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!q[i] && nxt[i])      {j_out[i], k_out[i]} = JK_SET;
      else if (q[i] && !nxt[i]) {j_out[i], k_out[i]} = JK_RESET;
      else                      {j_out[i], k_out[i]} = JK_HOLD;
    end
  end

  // Count storage: q only changes through the JK cells.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .clr (clr),
      .j   (j_out[g]),
      .k   (k_out[g]),
      .q   (q[g])
    );
  end

  // Mode FSM and the one-cycle clamp flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      ld.load_err <= 1'b0;
    end else begin
      ld.load_err <= accept & clamp;
      if (accept) begin
        state <= LOADED;
      end else begin
        case (state)
          IDLE:    state <= en ? RUN : IDLE;
          RUN:     state <= en ? RUN : IDLE;
          LOADED:  state <= en ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter (WIDTH=4, MODULUS=10).
import jk_pkg::*;

module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       clr, en, up;
  logic [3:0] q, j_out, k_out;
  logic       tc;
  logic [3:0] shadow;
  logic       shadow_on = 1'b0;
  int         nvec = 0;
  int         nerr = 0;

  jk_mod_counter_if #(.WIDTH(4)) ld ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .up    (up),
    .ld    (ld),
    .q     (q),
    .j_out (j_out),
    .k_out (k_out),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, en, up, lv;
    logic [3:0] lval;
    logic [3:0] q;      // expected q after the edge
    logic       err;    // expected load_err after the edge
    logic       tc;     // expected tc before the edge (current q, this up)
    state_t     st;     // expected state after the edge
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] prev_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic c, e, u, v, input logic [3:0] lval, input logic [3:0] eq,
                     input logic eerr, etc, input state_t est);
    vec_t t;
    t.clr = c; t.en = e; t.up = u; t.lv = v; t.lval = lval;
    t.q = eq; t.err = eerr; t.tc = etc; t.st = est;
    vecs.push_back(t);
  endtask

  // Drive one cycle: check combinational outputs before the edge, state after.
  task automatic apply(input vec_t v);
    clr = v.clr; en = v.en; up = v.up;
    ld.load_valid = v.lv; ld.load_value = v.lval;
    #1;
    chk("load_ready", ld.load_ready, !v.clr);
    if (!v.clr) begin
      chk("tc", tc, v.tc);
      chk("j_out", j_out, ~prev_q & v.q);
      chk("k_out", k_out, prev_q & ~v.q);
    end
    @(posedge clk); #1;
    chk("q", q, v.q);
    chk("load_err", ld.load_err, v.err);
    chk("state", ld.state, v.st);
    prev_q = v.q;
  endtask

  // External JK bank fed from the exported excitation.
  always @(posedge clk) begin
    if (clr) shadow <= '0;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({j_out[i], k_out[i]})
          2'b10:   shadow[i] <= 1'b1;
          2'b01:   shadow[i] <= 1'b0;
          2'b11:   shadow[i] <= ~shadow[i];
          default: shadow[i] <= shadow[i];
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (shadow_on) begin
      chk("shadow_bank", shadow, q);
      chk("no_jk_toggle", j_out & k_out, 4'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t h;
    clr = 1'b1; en = 1'b0; up = 1'b1;
    ld.load_valid = 1'b0; ld.load_value = '0;
    prev_q = '0;
    @(posedge clk); #1;

    // reset, then count up through the wrap
    add(1,0,0,0,4'd0,  4'd0,0,0,IDLE);
    add(1,1,1,1,4'd5,  4'd0,0,0,IDLE);
    for (int i = 0; i < 12; i++)
      add(0,1,1,0,4'd0, 4'((i + 1) % 10), 0, (i % 10) == 9, RUN);
    // down wrap from 0 (q=2 here)
    add(0,0,1,1,4'd0,  4'd0,0,0,LOADED);
    add(0,1,0,0,4'd0,  4'd9,0,1,RUN);
    add(0,1,0,0,4'd0,  4'd8,0,0,RUN);
    // clamped and in-range loads
    add(0,0,0,1,4'd13, 4'd9,1,0,LOADED);
    add(0,0,0,1,4'd5,  4'd5,0,0,LOADED);
    add(0,0,1,1,4'd15, 4'd9,1,0,LOADED);
    add(0,0,1,0,4'd0,  4'd9,0,1,IDLE);
    // load beats count, then LOADED -> RUN
    add(0,0,0,1,4'd3,  4'd3,0,0,LOADED);
    add(0,1,1,1,4'd7,  4'd7,0,0,LOADED);
    add(0,1,1,0,4'd0,  4'd8,0,0,RUN);
    // clear during counting with an out-of-range load pending
    add(0,0,1,1,4'd5,  4'd5,0,0,LOADED);
    add(0,1,1,0,4'd0,  4'd6,0,0,RUN);
    add(1,1,1,1,4'd12, 4'd0,0,0,IDLE);
    add(0,0,1,0,4'd0,  4'd0,0,0,IDLE);
    // hold at 4
    add(0,0,1,1,4'd4,  4'd4,0,0,LOADED);
    for (int i = 0; i < 5; i++)
      add(0,0,1,0,4'd0, 4'd4,0,0,IDLE);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      if (i == 0) shadow_on = 1'b1;
    end

    // tc is independent of en, and the clamp boundary sits exactly at MODULUS
    h = '{clr:0, en:0, up:0, lv:1, lval:4'd0,  q:4'd0, err:0, tc:0, st:LOADED}; apply(h);
    h = '{clr:0, en:0, up:0, lv:0, lval:4'd0,  q:4'd0, err:0, tc:1, st:IDLE};   apply(h);
    h = '{clr:0, en:0, up:1, lv:1, lval:4'd9,  q:4'd9, err:0, tc:0, st:LOADED}; apply(h);
    h = '{clr:0, en:0, up:1, lv:0, lval:4'd0,  q:4'd9, err:0, tc:1, st:IDLE};   apply(h);
    h = '{clr:0, en:0, up:0, lv:1, lval:4'd10, q:4'd9, err:1, tc:0, st:LOADED}; apply(h);
    h = '{clr:0, en:1, up:1, lv:0, lval:4'd0,  q:4'd0, err:0, tc:1, st:RUN};    apply(h);
    h = '{clr:0, en:1, up:0, lv:0, lval:4'd0,  q:4'd9, err:0, tc:1, st:RUN};    apply(h);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
